// File: rtl/ack_nak_gen_if.sv
// Packet-classification and ACK/NAK DLLP signals for ack_nak_gen.
// master drives packets and dllp_ready; slave is the generator.
interface ack_nak_gen_if;
    logic        pkt_valid;
    logic [11:0] pkt_seq;
    logic        pkt_crc_ok;
    logic        pkt_accept;
    logic        pkt_dup;
    logic        dllp_valid;
    logic        dllp_ready;
    logic        dllp_nak;
    logic [11:0] dllp_seq;
    logic [11:0] next_rcv_seq;

    modport master (
        output pkt_valid, pkt_seq, pkt_crc_ok, dllp_ready,
        input  pkt_accept, pkt_dup, dllp_valid, dllp_nak, dllp_seq, next_rcv_seq
    );

    modport slave (
        input  pkt_valid, pkt_seq, pkt_crc_ok, dllp_ready,
        output pkt_accept, pkt_dup, dllp_valid, dllp_nak, dllp_seq, next_rcv_seq
    );
endinterface

// File: rtl/ack_nak_gen.sv
// Receive-side ACK/NAK generator: classifies packets by sequence number and offers ACK/NAK DLLPs.
// Define ACK_COALESCE_EN to coalesce ACKs behind an ACK_LATENCY timer; otherwise ACK every accept.
module ack_nak_gen #(
    parameter int unsigned ACK_LATENCY = 8
) (
    input logic          clk,
    input logic          rst_n,
    ack_nak_gen_if.slave bus
);

    typedef enum logic [1:0] {Idle, AckWait, SendAck, SendNak} state_e;

    if (ACK_LATENCY < 1 || ACK_LATENCY > 255) begin : g_latency_check
        $error("ACK_LATENCY must be in 1..255");
    end

    state_e      state_q, state_d;
    logic [11:0] next_rcv_seq_q, next_rcv_seq_d;
    logic        nak_sched_q, nak_sched_d;
    logic        ack_pend_q, ack_pend_d;
    logic        dllp_nak_q, dllp_nak_d;
    logic [11:0] dllp_seq_q, dllp_seq_d;
    logic        pkt_accept_q, pkt_dup_q;

    logic [11:0] seq_dist;
    logic        is_accept, is_dup, is_nak, handshake, timer_expired;

    assign seq_dist  = next_rcv_seq_q - bus.pkt_seq;
    assign is_accept = bus.pkt_valid && bus.pkt_crc_ok && (seq_dist == 12'd0);
    assign is_dup    = bus.pkt_valid && bus.pkt_crc_ok && (seq_dist != 12'd0)
                       && (seq_dist <= 12'd2048);
    // Bad CRC and sequence gaps only NAK once until the next in-order packet.
    assign is_nak    = bus.pkt_valid && !is_accept && !is_dup && !nak_sched_q;
    assign handshake = (state_q == SendAck || state_q == SendNak) && bus.dllp_ready;

`ifdef ACK_COALESCE_EN
    localparam state_e         AckTarget = AckWait;
    localparam logic [7:0]     TimerLast = 8'(ACK_LATENCY - 1);

    logic [7:0] timer_q, timer_d;

    assign timer_expired = (state_q == AckWait) && (timer_q == TimerLast);
    assign timer_d       = (state_q == AckWait && state_d == AckWait) ? timer_q + 8'd1 : 8'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= 8'd0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    localparam state_e AckTarget = SendAck;

    assign timer_expired = 1'b0;
`endif

    always_comb begin
        next_rcv_seq_d = is_accept ? next_rcv_seq_q + 12'd1 : next_rcv_seq_q;

        nak_sched_d = nak_sched_q;
        if (is_accept) begin
            nak_sched_d = 1'b0;
        end else if (is_nak) begin
            nak_sched_d = 1'b1;
        end

        // A sent DLLP covers everything up to its seq; anything accepted since keeps ack_pend.
        ack_pend_d = ack_pend_q;
        if (handshake) begin
            ack_pend_d = (dllp_seq_q != next_rcv_seq_q - 12'd1);
        end
        if (is_accept || is_dup) begin
            ack_pend_d = 1'b1;
        end

        state_d = state_q;
        case (state_q)
            Idle: begin
                if (is_dup) begin
                    state_d = SendAck;
                end else if (ack_pend_q || is_accept) begin
                    state_d = AckTarget;
                end
            end
            AckWait: begin
                if (is_dup || timer_expired) begin
                    state_d = SendAck;
                end
            end
            SendAck, SendNak: begin
                if (handshake) begin
                    if (is_dup) begin
                        state_d = SendAck;
                    end else if (ack_pend_d) begin
                        state_d = AckTarget;
                    end else begin
                        state_d = Idle;
                    end
                end
            end
            default: state_d = Idle;
        endcase

        // A NAK already on offer is held until taken.
        if (is_nak && !(state_q == SendNak && !handshake)) begin
            state_d = SendNak;
        end

        dllp_seq_d = dllp_seq_q;
        dllp_nak_d = dllp_nak_q;
        if ((state_d == SendAck || state_d == SendNak) && (state_d != state_q || handshake)) begin
            dllp_seq_d = next_rcv_seq_d - 12'd1;
            dllp_nak_d = (state_d == SendNak);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= Idle;
            next_rcv_seq_q <= 12'd0;
            nak_sched_q    <= 1'b0;
            ack_pend_q     <= 1'b0;
            dllp_nak_q     <= 1'b0;
            dllp_seq_q     <= 12'hFFF;
            pkt_accept_q   <= 1'b0;
            pkt_dup_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            next_rcv_seq_q <= next_rcv_seq_d;
            nak_sched_q    <= nak_sched_d;
            ack_pend_q     <= ack_pend_d;
            dllp_nak_q     <= dllp_nak_d;
            dllp_seq_q     <= dllp_seq_d;
            pkt_accept_q   <= is_accept;
            pkt_dup_q      <= is_dup;
        end
    end

    assign bus.pkt_accept   = pkt_accept_q;
    assign bus.pkt_dup      = pkt_dup_q;
    assign bus.dllp_valid   = (state_q == SendAck) || (state_q == SendNak);
    assign bus.dllp_nak     = dllp_nak_q;
    assign bus.dllp_seq     = dllp_seq_q;
    assign bus.next_rcv_seq = next_rcv_seq_q;

endmodule

// File: tb/tb_ack_nak_gen.sv
// Scoreboard bench for ack_nak_gen: directed link scenarios plus randomized packet traffic
// checked against a sequence-number reference model.
module tb_ack_nak_gen;

    localparam int unsigned LAT = 5;
`ifdef ACK_COALESCE_EN
    localparam bit Coalesce = 1'b1;
`else
    localparam bit Coalesce = 1'b0;
`endif

    typedef struct {
        bit nak;
        int seq;
        int rel;
    } dllp_exp_t;

    logic clk = 1'b0;
    logic rst_n;
    ack_nak_gen_if bus ();

    ack_nak_gen #(.ACK_LATENCY(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int        vectors = 0;
    int        miscompares = 0;
    int        cyc = 0;
    int        first_acc_cyc = -1;
    int        model_next = 0;
    bit        model_nak = 1'b0;
    int        nak_sched_cnt = 0;
    int        naks_seen = 0;
    int        last_hs_seq = -1;
    bit        strict = 1'b1;
    int        exp_kind_q[$];
    int        exp_next_q[$];
    dllp_exp_t exp_dllp_q[$];
    dllp_exp_t mon_e;
    int        mon_k, mon_n;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Reference model: classify by modular distance from the expected sequence number.
    task automatic model_apply(input logic [11:0] seq, input logic crc);
        int d;
        d = (model_next - int'(seq) + 4096) % 4096;
        if (crc && d == 0) begin
            model_next = (model_next + 1) % 4096;
            model_nak  = 1'b0;
            exp_kind_q.push_back(1);
            exp_next_q.push_back(model_next);
        end else if (crc && d >= 1 && d <= 2048) begin
            exp_kind_q.push_back(2);
            exp_next_q.push_back(model_next);
        end else if (!model_nak) begin
            model_nak = 1'b1;
            nak_sched_cnt++;
        end
    endtask

    task automatic drive_pkt(input logic [11:0] seq, input logic crc);
        bus.pkt_valid  = 1'b1;
        bus.pkt_seq    = seq;
        bus.pkt_crc_ok = crc;
        model_apply(seq, crc);
        tick();
        bus.pkt_valid = 1'b0;
    endtask

    task automatic push_dllp(input bit nak, input int seq, input int rel);
        dllp_exp_t e;
        e.nak = nak;
        e.seq = seq;
        e.rel = rel;
        exp_dllp_q.push_back(e);
    endtask

    // Back-to-back in-order burst with dllp_ready held high.
    task automatic push_ack_burst(input int first, input int last, input bit timed);
        if (Coalesce) begin
            push_dllp(1'b0, last, timed ? int'(LAT) : -1);
        end else begin
            for (int s = first; s <= last; s++) push_dllp(1'b0, s, timed ? s - first : -1);
        end
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        bus.pkt_valid  = 1'b0;
        bus.pkt_seq    = 12'd0;
        bus.pkt_crc_ok = 1'b0;
        idle(2);
        exp_kind_q.delete();
        exp_next_q.delete();
        exp_dllp_q.delete();
        model_next    = 0;
        model_nak     = 1'b0;
        nak_sched_cnt = 0;
        naks_seen     = 0;
        last_hs_seq   = -1;
        first_acc_cyc = -1;
        rst_n         = 1'b1;
        tick();
    endtask

    task automatic end_test(input string name);
        check({name, "_pkt_q_left"}, exp_kind_q.size(), 0);
        check({name, "_dllp_q_left"}, exp_dllp_q.size(), 0);
        check({name, "_next_rcv_seq"}, bus.next_rcv_seq, model_next);
    endtask

    task automatic wait_dllp(input int limit, output bit found);
        found = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (bus.dllp_valid) begin
                found = 1'b1;
                break;
            end
            tick();
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.pkt_accept || bus.pkt_dup) begin
                if (bus.pkt_accept && first_acc_cyc < 0) first_acc_cyc = cyc;
                if (exp_kind_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL pkt_unexpected: accept=%0b dup=%0b, none expected",
                             bus.pkt_accept, bus.pkt_dup);
                end else begin
                    mon_k = exp_kind_q.pop_front();
                    mon_n = exp_next_q.pop_front();
                    check("pkt_kind", {bus.pkt_dup, bus.pkt_accept}, mon_k);
                    check("pkt_next_rcv_seq", bus.next_rcv_seq, mon_n);
                end
            end
            if (bus.dllp_valid && bus.dllp_ready) begin
                last_hs_seq = bus.dllp_seq;
                if (bus.dllp_nak) naks_seen++;
                if (strict) begin
                    if (exp_dllp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL dllp_unexpected: nak=%0b seq=0x%0h, none expected",
                                 bus.dllp_nak, bus.dllp_seq);
                    end else begin
                        mon_e = exp_dllp_q.pop_front();
                        check("dllp_nak", bus.dllp_nak, mon_e.nak);
                        check("dllp_seq", bus.dllp_seq, mon_e.seq);
                        if (mon_e.rel >= 0) check("dllp_latency", cyc - first_acc_cyc, mon_e.rel);
                    end
                end else begin
                    check("dllp_seq_window",
                          int'(((model_next - int'(bus.dllp_seq) - 1 + 8192) % 4096) < 2048), 1);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int valid_cycles;
        int r;

        bus.dllp_ready = 1'b0;
        do_reset();
        check("rst_next_rcv_seq", bus.next_rcv_seq, 0);
        check("rst_dllp_valid", bus.dllp_valid, 0);
        check("rst_dllp_nak", bus.dllp_nak, 0);
        check("rst_dllp_seq", bus.dllp_seq, 12'hFFF);
        check("rst_pkt_accept", bus.pkt_accept, 0);
        check("rst_pkt_dup", bus.pkt_dup, 0);

        // Four in-order packets, one coalesced ACK after the latency window.
        bus.dllp_ready = 1'b1;
        push_ack_burst(0, 3, 1'b1);
        for (int s = 0; s < 4; s++) drive_pkt(12'(s), 1'b1);
        idle(3 * LAT + 6);
        end_test("t1");

        // Repeated bad CRC yields a single NAK; the next good packet re-arms NAKing.
        do_reset();
        if (!Coalesce) push_dllp(1'b0, 0, -1);
        push_dllp(1'b1, 0, -1);
        drive_pkt(12'd0, 1'b1);
        drive_pkt(12'd1, 1'b0);
        drive_pkt(12'd1, 1'b0);
        idle(3 * LAT + 4);
        check("t2_next_after_nak", bus.next_rcv_seq, 1);
        push_dllp(1'b0, 1, -1);
        drive_pkt(12'd1, 1'b1);
        idle(3 * LAT + 4);
        push_dllp(1'b1, 1, -1);
        drive_pkt(12'd5, 1'b0);
        idle(4);
        end_test("t2");

        // Duplicate gets an immediate ACK; a forward gap gets a NAK.
        do_reset();
        push_ack_burst(0, 4, 1'b0);
        for (int s = 0; s < 5; s++) drive_pkt(12'(s), 1'b1);
        idle(3 * LAT + 4);
        push_dllp(1'b0, 4, -1);
        drive_pkt(12'd3, 1'b1);
        check("t3_dup_ack_immediate", bus.dllp_valid, 1);
        idle(4);
        push_dllp(1'b1, 4, -1);
        drive_pkt(12'd9, 1'b1);
        idle(4);
        end_test("t3");

        // NAK replaces a stalled ACK and keeps its seq until taken.
        do_reset();
        bus.dllp_ready = 1'b0;
        for (int s = 0; s < 3; s++) drive_pkt(12'(s), 1'b1);
        wait_dllp(3 * LAT + 10, found);
        check("t4_ack_offered", found, 1);
        check("t4_ack_nak_bit", bus.dllp_nak, 0);
        check("t4_ack_seq", bus.dllp_seq, Coalesce ? 2 : 0);
        drive_pkt(12'd3, 1'b0);
        check("t4_nak_replaces", bus.dllp_nak, 1);
        check("t4_nak_seq", bus.dllp_seq, 2);
        idle(3);
        check("t4_nak_held_valid", bus.dllp_valid, 1);
        check("t4_nak_held_seq", bus.dllp_seq, 2);
        push_dllp(1'b1, 2, -1);
        bus.dllp_ready = 1'b1;
        valid_cycles = 0;
        tick();
        for (int i = 0; i < 3 * int'(LAT) + 6; i++) begin
            if (bus.dllp_valid) valid_cycles++;
            tick();
        end
        check("t4_no_ack_after_nak", valid_cycles, 0);
        end_test("t4");

        // Randomized traffic with random back-pressure.
        do_reset();
        strict = 1'b0;
        for (int i = 0; i < 800; i++) begin
            bus.dllp_ready = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3, 4: drive_pkt(12'(model_next), 1'b1);
                5:             drive_pkt(12'($urandom_range(0, 4095)), 1'b0);
                6:             drive_pkt(12'((model_next + 4096 - $urandom_range(1, 2048)) % 4096),
                                         1'b1);
                7:             drive_pkt(12'((model_next + $urandom_range(1, 2047)) % 4096), 1'b1);
                default:       tick();
            endcase
        end
        bus.dllp_ready = 1'b1;
        idle(3 * LAT + 10);
        check("rand_last_dllp_covers_all", last_hs_seq, (model_next + 4095) % 4096);
        check("rand_idle_after_drain", bus.dllp_valid, 0);
        check("rand_nak_count_bound", int'(naks_seen <= nak_sched_cnt), 1);
        end_test("rand");

        // Sequence wrap, then asynchronous reset with a DLLP on offer.
        do_reset();
        for (int s = 0; s < 4095; s++) drive_pkt(12'(s), 1'b1);
        idle(3 * LAT + 10);
        strict = 1'b1;
        push_dllp(1'b0, 4095, -1);
        drive_pkt(12'd4095, 1'b1);
        idle(3 * LAT + 6);
        check("t5_wrap_next", bus.next_rcv_seq, 0);
        end_test("t5");
        bus.dllp_ready = 1'b0;
        drive_pkt(12'd0, 1'b1);
        wait_dllp(3 * LAT + 10, found);
        check("t5_dllp_offered", found, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_dllp_valid", bus.dllp_valid, 0);
        check("t5_async_next_rcv_seq", bus.next_rcv_seq, 0);
        check("t5_async_dllp_seq", bus.dllp_seq, 12'hFFF);
        check("t5_async_dllp_nak", bus.dllp_nak, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
